// File: rtl/sram_dp_bank.sv
// Simple-dual-port SRAM bank: byte-masked write port A, registered write-first read port B,
// zero-fill clear engine. Define SRAM_PARITY_EN for per-byte even parity with error injection.
module sram_dp_bank #(
    parameter int DW    = 32,
    parameter int AW    = 8,
    parameter int DEPTH = 256,
    localparam int BW   = DW / 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_a,
    input  logic          wen_a,
    input  logic [AW-1:0] addr_a,
    input  logic [BW-1:0] be_a,
    input  logic [DW-1:0] d_a,
`ifdef SRAM_PARITY_EN
    input  logic          par_inj_a,
    output logic          par_err_b,
`endif
    input  logic          en_b,
    input  logic [AW-1:0] addr_b,
    output logic [DW-1:0] q_b,
    output logic          q_valid_b,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          clr_done
);

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } state_t;

    state_t        state;
    logic [AW-1:0] cnt;

    logic [DW-1:0] mem [DEPTH];
    logic          a_in;
    logic          b_in;
    logic          wr_en;
    logic          fwd;
    logic [DW-1:0] rd_word;

    assign a_in  = ({1'b0, addr_a} < DEPTH_W);
    assign b_in  = ({1'b0, addr_b} < DEPTH_W);
    assign wr_en = en_a && !wen_a && !clr_busy && a_in;
    assign fwd   = wr_en && (addr_a == addr_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    clr_done <= 1'b0;
                    if (clr_req) begin
                        state    <= CLEAR;
                        cnt      <= '0;
                        clr_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state    <= DONE;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    clr_done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage is deliberately unreset; only the clear engine zero-fills it.
    always_ff @(posedge clk) begin
        if (clr_busy) begin
            mem[cnt] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < BW; i++) begin
                if (be_a[i]) mem[addr_a][8*i +: 8] <= d_a[8*i +: 8];
            end
        end
    end

    always_comb begin
        rd_word = mem[addr_b];
        for (int i = 0; i < BW; i++) begin
            if (fwd && be_a[i]) rd_word[8*i +: 8] = d_a[8*i +: 8];
        end
    end

`ifdef SRAM_PARITY_EN
    logic [BW-1:0] par_mem [DEPTH];
    logic [BW-1:0] wr_par;
    logic [BW-1:0] rd_par;
    logic [BW-1:0] rd_chk;

    always_comb begin
        wr_par = '0;
        rd_par = par_mem[addr_b];
        rd_chk = '0;
        for (int i = 0; i < BW; i++) begin
            wr_par[i] = (^d_a[8*i +: 8]) ^ par_inj_a;
            if (fwd && be_a[i]) rd_par[i] = wr_par[i];
            rd_chk[i] = (^rd_word[8*i +: 8]) ^ rd_par[i];
        end
    end

    always_ff @(posedge clk) begin
        if (clr_busy) begin
            par_mem[cnt] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < BW; i++) begin
                if (be_a[i]) par_mem[addr_a][i] <= wr_par[i];
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_b       <= '0;
            q_valid_b <= 1'b0;
`ifdef SRAM_PARITY_EN
            par_err_b <= 1'b0;
`endif
        end else if (en_b && !clr_busy) begin
            q_b       <= b_in ? rd_word : '0;
            q_valid_b <= 1'b1;
`ifdef SRAM_PARITY_EN
            par_err_b <= b_in && (|rd_chk);
`endif
        end else begin
            q_valid_b <= 1'b0;
`ifdef SRAM_PARITY_EN
            par_err_b <= 1'b0;
`endif
        end
    end

endmodule
